// File: rtl/rx_sft_if.sv
// UART receive shifter bus: serial line, oversample strobe and RX FIFO write side.
interface rx_sft_if #(
  parameter int unsigned DATA_W = 8
);

  logic              ena;
  logic              rxd;
  logic              rx_fifo_wfull;
  logic              rx_fifo_wen;
  logic [DATA_W-1:0] rx_fifo_wdata;
  logic              frm_err;
  logic              ovf_err;
  logic              work;

  // Receiver side: consumes line and strobe, writes the FIFO and raises flags.
  modport master (
    input  ena,
    input  rxd,
    input  rx_fifo_wfull,
    output rx_fifo_wen,
    output rx_fifo_wdata,
    output frm_err,
    output ovf_err,
    output work
  );

  // Environment side: drives line, strobe and FIFO status, observes results.
  modport slave (
    output ena,
    output rxd,
    output rx_fifo_wfull,
    input  rx_fifo_wen,
    input  rx_fifo_wdata,
    input  frm_err,
    input  ovf_err,
    input  work
  );

endinterface

// File: rtl/rx_sft.sv
// UART 8N1 receive shifter: 16x oversampling, start-bit qualification,
// 3-sample majority vote per bit, pushes good bytes into the RX FIFO.
module rx_sft #(
  parameter int unsigned OVS    = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  rx_sft_if.master bus
);

  localparam int unsigned SUB_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  localparam logic [SUB_W-1:0] SUB_SMP0 = SUB_W'(6);
  localparam logic [SUB_W-1:0] SUB_SMP1 = SUB_W'(7);
  localparam logic [SUB_W-1:0] SUB_VOTE = SUB_W'(8);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                rxd_m_q, rxd_s_q;
  logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]          smp_q, smp_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                frm_q, frm_d;
  logic                ovf_q, ovf_d;
  logic                work_q, work_d;
  logic                vote_c;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= bus.rxd;
      rxd_s_q <= rxd_m_q;
    end
  end

  // Majority of the samples at sub_cnt 6, 7 and the live sample at 8.
  assign vote_c = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sub_cnt_q <= '0;
      bit_cnt_q <= '0;
      smp_q     <= '0;
      sr_q      <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovf_q     <= 1'b0;
      work_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_cnt_q <= sub_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      sr_q      <= sr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      frm_q     <= frm_d;
      ovf_q     <= ovf_d;
      work_q    <= work_d;
    end
  end

  // Next-state logic; everything advances only on ena ticks. sub_cnt_q holds
  // the bit-phase of the next ena tick, so the start-detect tick is phase 0
  // and the stop-bit decision lands 152 ticks after it.
  always_comb begin
    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    sr_d      = sr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    frm_d     = 1'b0;
    ovf_d     = 1'b0;
    work_d    = work_q;

    if (bus.ena) begin
      sub_cnt_d = sub_cnt_q + SUB_W'(1);
      if (sub_cnt_q == SUB_SMP0) smp_d[0] = rxd_s_q;
      if (sub_cnt_q == SUB_SMP1) smp_d[1] = rxd_s_q;

      case (state_q)
        IDLE: begin
          sub_cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = START;
            sub_cnt_d = SUB_W'(1);
            work_d    = 1'b1;
          end
        end
        START: begin
          if (sub_cnt_q == SUB_VOTE && vote_c) begin
            state_d = IDLE;
            work_d  = 1'b0;
          end else if (sub_cnt_q == SUB_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (sub_cnt_q == SUB_VOTE) sr_d = {vote_c, sr_q[DATA_W-1:1]};
          if (sub_cnt_q == SUB_LAST) begin
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
            else bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop lets the next start edge arrive half a bit early.
          if (sub_cnt_q == SUB_VOTE) begin
            if (vote_c) begin
              state_d = IDLE;
              work_d  = 1'b0;
              if (!bus.rx_fifo_wfull) begin
                wdata_d = sr_q;
                wen_d   = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              frm_d   = 1'b1;
              state_d = BRK;
            end
          end
        end
        BRK: begin
          // Hold off re-triggering until the line returns high.
          if (rxd_s_q) begin
            state_d = IDLE;
            work_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          work_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_fifo_wen   = wen_q;
  assign bus.rx_fifo_wdata = wdata_q;
  assign bus.frm_err       = frm_q;
  assign bus.ovf_err       = ovf_q;
  assign bus.work          = work_q;

endmodule

// File: tb/tb_rx_sft.sv
// Directed bench for rx_sft: drives 8N1 frames at 16 ena ticks per bit.
module tb_rx_sft;

  logic clk;
  logic rst;

  rx_sft_if #(.DATA_W(8)) bus ();

  rx_sft #(.OVS(16), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned wen_cnt;
  int unsigned frm_cnt;
  int unsigned ovf_cnt;
  int unsigned both_cnt;
  logic [7:0]  rx_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ena: one clk high every 4 clks, changed on the falling edge.
  initial begin
    int cnt;
    cnt     = 0;
    bus.ena = 1'b0;
    forever begin
      @(negedge clk);
      bus.ena = (cnt == 3);
      cnt     = (cnt + 1) % 4;
    end
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.rx_fifo_wen) begin
      wen_cnt++;
      rx_log.push_back(bus.rx_fifo_wdata);
    end
    if (bus.frm_err) frm_cnt++;
    if (bus.ovf_err) ovf_cnt++;
    if (bus.rx_fifo_wen && bus.ovf_err) both_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.ena) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int ticks);
    @(negedge clk);
    bus.rxd = b;
    wait_ticks(ticks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(stop_b, 16);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_wen"}, 32'(bus.rx_fifo_wen), 32'd0);
    check({tag, "_frm"}, 32'(bus.frm_err), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf_err), 32'd0);
    check({tag, "_work"}, 32'(bus.work), 32'd0);
  endtask

  initial begin
    int unsigned w0;
    n_chk             = 0;
    n_fail            = 0;
    wen_cnt           = 0;
    frm_cnt           = 0;
    ovf_cnt           = 0;
    both_cnt          = 0;
    rst               = 1'b0;
    bus.rxd           = 1'b1;
    bus.rx_fifo_wfull = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check_outputs_idle("rst");
    check("rst_wdata", 32'(bus.rx_fifo_wdata), 32'd0);
    rst = 1'b1;
    wait_ticks(4);

    // T1 good frame 0xA5
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t1_wen_cnt", wen_cnt, 32'd1);
    check("t1_wdata", 32'(bus.rx_fifo_wdata), 32'hA5);
    check("t1_frm", frm_cnt, 32'd0);
    check("t1_ovf", ovf_cnt, 32'd0);
    check("t1_work", 32'(bus.work), 32'd0);

    // T2 glitch of 5 ticks, then a real 0x3C
    send_bit(1'b0, 5);
    send_bit(1'b1, 24);
    @(negedge clk);
    check("t2_glitch_wen", wen_cnt, 32'd1);
    check("t2_glitch_flags", frm_cnt + ovf_cnt, 32'd0);
    check("t2_glitch_work", 32'(bus.work), 32'd0);
    send_frame(8'h3C, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t2_wen_cnt", wen_cnt, 32'd2);
    check("t2_wdata", 32'(bus.rx_fifo_wdata), 32'h3C);

    // T3 framing error: stop low, line low for 3 bit-times
    send_frame(8'h55, 1'b0);
    send_bit(1'b0, 32);
    @(negedge clk);
    check("t3_frm_cnt", frm_cnt, 32'd1);
    check("t3_wen_cnt", wen_cnt, 32'd2);
    check("t3_work_brk", 32'(bus.work), 32'd1);
    send_bit(1'b1, 16);
    @(negedge clk);
    check("t3_work_idle", 32'(bus.work), 32'd0);
    send_frame(8'h12, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t3_wen_cnt2", wen_cnt, 32'd3);
    check("t3_wdata", 32'(bus.rx_fifo_wdata), 32'h12);
    check("t3_frm_cnt2", frm_cnt, 32'd1);

    // T4 overflow with FIFO full
    bus.rx_fifo_wfull = 1'b1;
    send_frame(8'h7E, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t4_ovf_cnt", ovf_cnt, 32'd1);
    check("t4_wen_cnt", wen_cnt, 32'd3);
    check("t4_wdata_kept", 32'(bus.rx_fifo_wdata), 32'h12);
    bus.rx_fifo_wfull = 1'b0;

    // T5 back-to-back 0x00, 0xFF with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t5_wen_cnt", wen_cnt, 32'd5);
    check("t5_data0", 32'(rx_log[3]), 32'h00);
    check("t5_data1", 32'(rx_log[4]), 32'hFF);
    check("t5_flags", frm_cnt + ovf_cnt, 32'd2);

    // T6 reset during bit 4 of 0x99
    w0 = wen_cnt;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h99 >> i), 16);
    send_bit(1'b1, 8);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_idle("t6_in_rst");
    check("t6_wdata", 32'(bus.rx_fifo_wdata), 32'd0);
    bus.rxd = 1'b1;
    rst     = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    check_outputs_idle("t6_after");
    check("t6_no_write", wen_cnt, w0);
    send_frame(8'h42, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("t6_wen_cnt", wen_cnt, w0 + 1);
    check("t6_wdata42", 32'(bus.rx_fifo_wdata), 32'h42);

    // wen and ovf_err never together
    check("wen_ovf_exclusive", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
